// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared width and FSM encodings for the unified-memory arbiter
package mem_arbiter_pkg;
    localparam int XLEN = 64;
    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_BUSY_I = 2'd1;
    localparam logic [1:0] ARB_BUSY_D = 2'd2;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory buses seen by the arbiter
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;
    logic            if_req_i;
    logic [XLEN-1:0] if_addr_i;
    logic            if_gnt_o;
    logic            if_rvalid_o;
    logic [31:0]     if_rdata_o;
    logic            d_req_i;
    logic            d_we_i;
    logic [XLEN-1:0] d_addr_i;
    logic [XLEN-1:0] d_wdata_i;
    logic [7:0]      d_wmask_i;
    logic            d_gnt_o;
    logic            d_rvalid_o;
    logic [XLEN-1:0] d_rdata_o;
    logic            mem_req_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic [7:0]      mem_wmask_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wmask_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o
    );

    modport master (
        output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wmask_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: one-outstanding arbiter, data priority with a streak limit against fetch starvation
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          bit2_q, bit2_d;
    logic          idle, d_win, arb_req, if_gnt, d_gnt, d_store;
    logic          unused_addr;

    always_comb begin
        idle    = !rst && state_q == ARB_IDLE;
        d_win   = bus.d_req_i && !(bus.if_req_i && streak_q == STREAK_MAX);
        arb_req = idle && (bus.if_req_i || bus.d_req_i);
        d_gnt   = arb_req && d_win && bus.mem_gnt_i;
        if_gnt  = arb_req && !d_win && bus.mem_gnt_i;
        d_store = arb_req && d_win && bus.d_we_i;
    end

    assign bus.mem_req_o   = arb_req;
    assign bus.mem_we_o    = d_store;
    assign bus.mem_addr_o  = !arb_req ? '0 :
                             d_win ? {bus.d_addr_i[XLEN-1:3], 3'b000} : {bus.if_addr_i[XLEN-1:3], 3'b000};
    assign bus.mem_wdata_o = d_store ? bus.d_wdata_i : '0;
    assign bus.mem_wmask_o = d_store ? bus.d_wmask_i : '0;
    assign bus.if_gnt_o    = if_gnt;
    assign bus.d_gnt_o     = d_gnt;
    assign bus.if_rvalid_o = !rst && state_q == ARB_BUSY_I && bus.mem_rvalid_i;
    assign bus.d_rvalid_o  = !rst && state_q == ARB_BUSY_D && bus.mem_rvalid_i;
    assign bus.if_rdata_o  = rst ? '0 : bit2_q ? bus.mem_rdata_i[63:32] : bus.mem_rdata_i[31:0];
    assign bus.d_rdata_o   = rst ? '0 : bus.mem_rdata_i;
    assign unused_addr     = ^{bus.if_addr_i[1:0], bus.d_addr_i[2:0]};

    // A data grant only grows the streak when a fetch was actually kept waiting
    always_comb begin
        state_d  = d_gnt ? ARB_BUSY_D :
                   if_gnt ? ARB_BUSY_I :
                   (state_q != ARB_IDLE && bus.mem_rvalid_i) ? ARB_IDLE : state_q;
        streak_d = if_gnt ? '0 :
                   !d_gnt ? streak_q :
                   !bus.if_req_i ? '0 :
                   streak_q == STREAK_MAX ? streak_q : streak_q + 1'b1;
        bit2_d   = if_gnt ? bus.if_addr_i[2] : bit2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            streak_q <= '0;
            bit2_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            bit2_q   <= bit2_d;
        end
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single-port unified memory between the instruction-fetch requester (ifetch) and the load/store requester (mem stage). Exactly one transaction is outstanding at a time. Data accesses have priority over fetches, and a streak limit prevents fetch starvation. The block sits between the pipeline stages and the memory model, and replaces the direct pc-to-memory connection in top.

## Interface
- MAX_D_STREAK, default 4: consecutive contested data grants allowed before a pending fetch must win; 0 = fetch always wins contention.
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- if_req_i  in  1  fetch request; held with if_addr_i stable until if_gnt_o
- if_addr_i  in  64  fetch address, bits[1:0] = 0
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch data valid
- if_rdata_o  out  32  instruction word
- d_req_i  in  1  data request; held with d_we_i, d_addr_i, d_wdata_i and d_wmask_i stable until d_gnt_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  64  data address, 8-byte aligned
- d_wdata_i  in  64  store data
- d_wmask_i  in  8  store byte enables
- d_gnt_o  out  1  data request accepted
- d_rvalid_o  out  1  load data valid, or store acknowledge
- d_rdata_o  out  64  load data
- mem_req_o  out  1  request to memory
- mem_we_o  out  1  write enable
- mem_addr_o  out  64  address with bits[2:0] forced to 0
- mem_wdata_o  out  64  write data
- mem_wmask_o  out  8  byte enables; 0 on reads
- mem_gnt_i  in  1  memory accepts the request this cycle
- mem_rvalid_i  in  1  response valid; latency ≥1 cycle after the accept
- mem_rdata_i  in  64  response data

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - BUSY_I: fetch outstanding.
  - BUSY_D: data access outstanding.
- IDLE: choose a winner among the asserted requests.
  - Data wins, except when both are requesting and streak == MAX_D_STREAK; then fetch wins.
  - The winner's fields drive mem_*, and mem_req_o = 1.
  - If mem_gnt_i = 1, assert the winner's gnt, go to BUSY_I or BUSY_D, and latch if_addr_i[2] when fetch wins.
  - If mem_gnt_i = 0, no gnt; re-arbitrate next cycle. The winner may change.
- BUSY_x: mem_req_o = 0 and both gnt = 0.
  - When mem_rvalid_i = 1, pass it to the owner's rvalid and return to IDLE.
- Fetch data: if_rdata_o = latched bit2 ? mem_rdata_i[63:32] : mem_rdata_i[31:0].
- d_rdata_o = mem_rdata_i. Stores also receive d_rvalid_o; the data is don't-care.
- Streak counter, width clog2(MAX_D_STREAK+1), saturating:
  - +1 on a data grant while if_req_i = 1.
  - Cleared on a data grant while if_req_i = 0.
  - Cleared on any fetch grant.
- mem_rvalid_i in IDLE (stray, e.g. after reset) is ignored. No rvalid is produced.
- The rvalid output of the non-owning requester is always 0.
- mem_wdata_o and mem_wmask_o are 0 unless a data store is the current winner.

## Timing
- Reset:
  - State IDLE, streak 0, latched bit2 0.
  - While reset = 1, all outputs are 0, including the combinational gnt and mem_req_o.
- Request to gnt: combinational, same cycle, when IDLE and mem_gnt_i = 1.
- rvalid outputs are combinational from mem_rvalid_i in the response cycle.
- After a response the FSM spends one cycle in IDLE before the next grant. Peak throughput is one transaction per (memory latency + 1) cycles.
- Reset mid-transaction: abort to IDLE. The owner receives no rvalid. Requesters are reset by the same signal.
- A request raised during BUSY waits. It is considered in the first IDLE cycle.

## Structure
- Shared package define.v holds:
  - XLEN = 64.
  - State encodings ARB_IDLE = 2'd0, ARB_BUSY_I = 2'd1, ARB_BUSY_D = 2'd2.
- Single module, no sub-module. The FSM, streak counter and output muxes are inline.
- top instantiates mem_arbiter between IF/MEM and MEMORY.

## Test plan
- Fetch only, memory latency 1: if_req_i at 0x1004 with mem_gnt_i = 1.
  - if_gnt_o the same cycle, mem_addr_o = 0x1000.
  - Next cycle mem_rvalid_i with rdata 0xAAAA_BBBB_CCCC_DDDD, so if_rvalid_o = 1 and if_rdata_o = 0xAAAABBBB.
- Load and fetch raised together, streak 0: d_gnt_o first. The fetch is granted in the IDLE cycle after d_rvalid_o.
- Starvation, MAX_D_STREAK = 4: d_req_i and if_req_i held continuously.
  - Grant order is D,D,D,D,I,D,D,D,D,I.
  - Streak reads 0 after each I grant.
- Store 0x1122334455667788 to 0x2000 with mask 0x0F.
  - mem_we_o = 1 and mem_wmask_o = 0x0F at the grant.
  - d_rvalid_o on the ack; if_rvalid_o stays 0.
- Stall: mem_gnt_i = 0 for 3 cycles with fetch pending. No gnt for those cycles. A data request appearing on cycle 2 takes the grant once mem_gnt_i = 1.
- Reset asserted while in BUSY_D:
  - Outputs go to 0 and the FSM returns to IDLE.
  - A later stray mem_rvalid_i produces no rvalid.
  - The next if_req_i is granted normally.
